// File: rtl/nx1_arb_pkg.sv
// Shared types and width helpers for the nx1 group arbiter and its round-robin picker.
package nx1_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned TAG_W = 8;

    // Tag that travels with each lane beat; fields sized for up to 256 sources/lanes.
    typedef struct packed {
        logic [TAG_W-1:0] src;
        logic [TAG_W-1:0] lane;
        logic             last;
    } group_tag_t;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import nx1_arb_pkg::*;
#(
    parameter int unsigned M   = 4,
    parameter int unsigned M_L = clog2_min1(M)
) (
    input  logic [M-1:0]   req,
    input  logic [M_L-1:0] ptr,
    output logic [M-1:0]   gnt,
    output logic [M_L-1:0] idx,
    output logic           any
);

    logic [M_L-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < M; i++) begin
            cand = M_L'((32'(ptr) + i) % M);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/nx1_group_arbiter.sv
// Round-robin arbiter granting one nx1 lane FIFO for a whole group at a time,
// feeding a single registered valid/ready output.
module nx1_group_arbiter
    import nx1_arb_pkg::*;
#(
    parameter int unsigned M     = 4,
    parameter int unsigned M_L   = clog2_min1(M),
    parameter int unsigned N     = 8,
    parameter int unsigned N_L   = clog2_min1(N),
    parameter int unsigned WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M-1:0]          src_not_empty,
    input  logic [M-1:0][WIDTH-1:0] src_data,
    output logic [M-1:0]          src_rd_req,
    output logic [M-1:0]          src_rd_all,
    input  logic                  abort,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [M_L-1:0]        out_src,
    output logic [N_L-1:0]        out_lane,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [31:0]           groups_done
);

    state_t         state;
    logic [M_L-1:0] rr_ptr;
    logic [M_L-1:0] grant;
    logic [N_L-1:0] lane;

    logic           slot_free;
    logic           pop;
    logic           pop_last;
    logic           abort_go;
    logic [M_L-1:0] pop_src;
    logic [N_L-1:0] pop_lane;

    logic [M-1:0]   pick_gnt;
    logic [M_L-1:0] pick_idx;
    logic           pick_any;

    rr_pick #(
        .M   (M),
        .M_L (M_L)
    ) u_pick (
        .req (src_not_empty),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    function automatic logic [M_L-1:0] next_src(input logic [M_L-1:0] s);
        return (s == M_L'(M - 1)) ? '0 : s + 1'b1;
    endfunction

    assign busy = (state == LOCKED);

    always_comb begin
        slot_free  = ~out_valid | out_ready;
        src_rd_req = '0;
        src_rd_all = '0;
        pop        = 1'b0;
        abort_go   = 1'b0;
        pop_src    = grant;
        pop_lane   = lane;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (pick_any && slot_free) begin
                        pop        = 1'b1;
                        pop_src    = pick_idx;
                        pop_lane   = '0;
                        src_rd_req = pick_gnt;
                    end
                end
                LOCKED: begin
                    // Abort discards the rest of the group without touching the output slot.
                    if (abort) begin
                        abort_go          = 1'b1;
                        src_rd_req[grant] = 1'b1;
                        src_rd_all[grant] = 1'b1;
                    end else if (src_not_empty[grant] && slot_free) begin
                        pop               = 1'b1;
                        src_rd_req[grant] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        pop_last = (pop_lane == N_L'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            lane        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= '0;
            out_lane    <= '0;
            out_last    <= 1'b0;
            groups_done <= '0;
        end else begin
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= src_data[pop_src];
                out_src   <= pop_src;
                out_lane  <= pop_lane;
                out_last  <= pop_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (abort_go) begin
                state  <= IDLE;
                rr_ptr <= next_src(grant);
                lane   <= '0;
            end else if (pop) begin
                if (pop_last) begin
                    state       <= IDLE;
                    rr_ptr      <= next_src(pop_src);
                    lane        <= '0;
                    groups_done <= groups_done + 32'd1;
                end else begin
                    state <= LOCKED;
                    grant <= pop_src;
                    lane  <= pop_lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nx1_group_arbiter.sv
// Scoreboard bench for nx1_group_arbiter: group-level reference model plus source FIFO models.
module tb_nx1_group_arbiter;
    import nx1_arb_pkg::*;

    localparam int M     = 4;
    localparam int N     = 8;
    localparam int WIDTH = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [M-1:0]           src_not_empty;
    logic [M-1:0][WIDTH-1:0] src_data;
    logic [M-1:0]           src_rd_req;
    logic [M-1:0]           src_rd_all;
    logic                   abort;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [1:0]             out_src;
    logic [2:0]             out_lane;
    logic                   out_last;
    logic                   out_ready;
    logic                   busy;
    logic [31:0]            groups_done;

    always #5 clk = ~clk;

    nx1_group_arbiter #(
        .M     (M),
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_not_empty (src_not_empty),
        .src_data      (src_data),
        .src_rd_req    (src_rd_req),
        .src_rd_all    (src_rd_all),
        .abort         (abort),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_lane      (out_lane),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .busy          (busy),
        .groups_done   (groups_done)
    );

    typedef struct {
        logic [63:0] data;
        group_tag_t  tag;
    } beat_t;

    beat_t       sb[$];
    logic [63:0] fifo[M][$];

    int          tests = 0;
    int          fails = 0;
    int          lock_src = -1;
    int          lock_lane = 0;
    int          rr = 0;
    int unsigned exp_done = 0;
    bit          exp_ov = 1'b0;
    bit          rst_i = 1'b1;
    bit          ready_i = 1'b1;
    bit          abort_i = 1'b0;
    logic [M-1:0] gate = '0;
    int          seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic push_group(input int s);
        for (int l = 0; l < N; l++) begin
            fifo[s].push_back({8'(s), 24'(seq), $urandom});
            seq++;
        end
    endtask

    // Reference: lock a source for one whole group, else pick the first ready source from rr.
    task automatic model_step();
        logic [M-1:0] er;
        logic [M-1:0] ea;
        bit           beat;
        bit           slot;
        int           bs;
        int           bl;
        int           s;
        beat_t        b;
        if (rst) begin
            chk("rst_rd_req", 64'(src_rd_req), 64'(0));
            chk("rst_rd_all", 64'(src_rd_all), 64'(0));
            lock_src  = -1;
            lock_lane = 0;
            rr        = 0;
            exp_done  = 0;
            exp_ov    = 1'b0;
            sb.delete();
            for (int k = 0; k < M; k++) fifo[k].delete();
            return;
        end
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("busy", 64'(busy), 64'(lock_src >= 0));
        chk("groups_done", 64'(groups_done), 64'(exp_done));
        er   = '0;
        ea   = '0;
        beat = 1'b0;
        bs   = 0;
        bl   = 0;
        slot = !exp_ov || out_ready;
        if (lock_src >= 0) begin
            if (abort) begin
                er[lock_src] = 1'b1;
                ea[lock_src] = 1'b1;
                for (int k = lock_lane; k < N; k++)
                    if (fifo[lock_src].size() > 0) void'(fifo[lock_src].pop_front());
                rr        = (lock_src + 1) % M;
                lock_src  = -1;
                lock_lane = 0;
            end else if (src_not_empty[lock_src] && slot) begin
                beat = 1'b1;
                bs   = lock_src;
                bl   = lock_lane;
            end
        end else begin
            for (int k = 0; k < M; k++) begin
                s = (rr + k) % M;
                if (!beat && src_not_empty[s] && slot) begin
                    beat = 1'b1;
                    bs   = s;
                    bl   = 0;
                end
            end
        end
        if (beat) begin
            er[bs]      = 1'b1;
            b.data      = fifo[bs].pop_front();
            b.tag.src   = 8'(bs);
            b.tag.lane  = 8'(bl);
            b.tag.last  = (bl == N - 1);
            sb.push_back(b);
            if (bl == N - 1) begin
                exp_done++;
                rr        = (bs + 1) % M;
                lock_src  = -1;
                lock_lane = 0;
            end else begin
                lock_src  = bs;
                lock_lane = bl + 1;
            end
        end
        chk("rd_req", 64'(src_rd_req), 64'(er));
        chk("rd_all", 64'(src_rd_all), 64'(ea));
        exp_ov = beat ? 1'b1 : (out_ready ? 1'b0 : exp_ov);
    endtask

    task automatic cycle();
        @(negedge clk);
        rst       = rst_i;
        out_ready = ready_i;
        abort     = abort_i;
        for (int s = 0; s < M; s++) begin
            src_not_empty[s] = (fifo[s].size() > 0) && !gate[s];
            src_data[s]      = (fifo[s].size() > 0) ? fifo[s][0] : '0;
        end
        #1;
        model_step();
    endtask

    function automatic bit all_idle();
        bit e = 1'b1;
        for (int s = 0; s < M; s++) if (fifo[s].size() > 0) e = 1'b0;
        return e && lock_src < 0 && sb.size() == 0 && !exp_ov;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        ready_i = 1'b1;
        abort_i = 1'b0;
        gate    = '0;
        while (!all_idle() && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) timeout("drain");
    endtask

    task automatic wait_lock(input int s, input int ln, input int budget);
        int n = 0;
        while (!(lock_src == s && lock_lane == ln) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) timeout("wait_lock");
    endtask

    // Monitor: every accepted beat must match the oldest expected beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", 64'(out_valid), 64'(0));
                end else begin
                    b = sb.pop_front();
                    chk("beat_data", out_data, b.data);
                    chk("beat_src", 64'(out_src), 64'(b.tag.src));
                    chk("beat_lane", 64'(out_lane), 64'(b.tag.lane));
                    chk("beat_last", 64'(out_last), 64'(b.tag.last));
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        abort         = 1'b0;
        out_ready     = 1'b1;
        src_not_empty = '0;
        src_data      = '0;

        repeat (3) cycle();
        rst_i = 1'b0;
        cycle();
        chk("reset_out_data", out_data, 64'(0));
        chk("reset_out_src", 64'(out_src), 64'(0));
        chk("reset_out_lane", 64'(out_lane), 64'(0));
        chk("reset_out_last", 64'(out_last), 64'(0));

        // Single group from source 2.
        push_group(2);
        drain(200);
        chk("single_group_done", 64'(groups_done), 64'(1));

        // Two sources competing: groups alternate 0,1,0,1.
        push_group(0);
        push_group(1);
        push_group(0);
        push_group(1);
        drain(400);

        // Backpressure mid-group.
        push_group(3);
        wait_lock(3, 2, 50);
        ready_i = 1'b1; cycle();
        ready_i = 1'b0; cycle(); cycle();
        ready_i = 1'b1; cycle();
        drain(200);

        // Granted source stalls at lane 3 while source 3 waits.
        push_group(1);
        push_group(3);
        wait_lock(1, 3, 50);
        gate = 4'b0010;
        repeat (5) cycle();
        gate = '0;
        drain(300);

        // Abort at lane 4.
        push_group(0);
        push_group(1);
        wait_lock(0, 4, 50);
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        drain(300);

        // Randomized traffic, backpressure, stalls and aborts.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) push_group(int'($urandom_range(0, M - 1)));
            ready_i = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < M; s++) gate[s] = ($urandom_range(0, 9) == 0);
            abort_i = ($urandom_range(0, 29) == 0);
            cycle();
        end
        drain(3000);

        // Reset mid-group, then arbitration restarts from source 0.
        push_group(2);
        wait_lock(2, 5, 50);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        push_group(1);
        push_group(0);
        cycle();
        chk("post_rst_groups_done", 64'(groups_done), 64'(0));
        drain(300);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nx1_group_arbiter.md
Name: nx1_group_arbiter

Overview:
- Round-robin arbiter that shares one downstream consumer among M showahead N-to-1 lane FIFOs.
- Each source FIFO holds groups of N lanes, written in parallel and read one lane per pop.
- Once a source is granted, the arbiter holds the grant for a whole group (lanes 0..N-1, or until abort). Groups from different sources therefore never interleave downstream.
- Sits between the per-engine nx1 FIFO banks and the shared reduction/output pipe.

Parameters:
- M, 4, number of requesting nx1 FIFOs
- M_L, $clog2(M), source index width (min 1)
- N, 8, lanes per group; must match the nx1 FIFO N
- N_L, $clog2(N), lane index width (min 1)
- WIDTH, 64, lane data width

Ports:
- clk  in  1  single clock, shared with the FIFO read side
- rst  in  1  synchronous, active-high reset
- src_not_empty  in  M  per-source showahead valid (current lane present)
- src_data  in  M x WIDTH  per-source showahead current-lane data
- src_rd_req  out  M  per-source pop, combinational, one-hot or zero
- src_rd_all  out  M  per-source discard-rest-of-group, qualifies src_rd_req
- abort  in  1  discard remainder of the currently locked group
- out_valid  out  1  registered output valid
- out_data  out  WIDTH  registered lane data
- out_src  out  M_L  source of out_data
- out_lane  out  N_L  lane index of out_data
- out_last  out  1  out_data is lane N-1
- out_ready  in  1  downstream accept
- busy  out  1  grant locked (state LOCKED)
- groups_done  out  32  completed-group counter, wraps

Behaviour:
- Reset values: state IDLE, rr pointer 0, lane 0, all out_* 0, busy 0, groups_done 0. src_rd_req and src_rd_all are 0 while rst is high.
- slot_free = ~out_valid | out_ready. All pops require slot_free.
- Output register: a pop loads out_data, out_src, out_lane and out_last, and sets out_valid the next cycle. Latency is 1 cycle from pop to out_valid.
  - If out_ready is high and there is no pop, out_valid clears.
  - Data is held stable while out_valid & ~out_ready.
- IDLE state:
  - Pick the first s with src_not_empty[s], searching from the rr pointer upward and wrapping.
  - If a source is found and slot_free: pulse src_rd_req[s], emit lane 0, set grant g=s and lane=1.
  - Go to LOCKED, or stay in IDLE if N==1. With N==1, out_last=1 and the group completes immediately.
  - If no candidate or not slot_free: no pop, stay in IDLE.
- LOCKED state: only source g may pop.
  - Pop when src_not_empty[g] & slot_free, then lane++.
  - The pop at lane N-1 sets out_last=1, increments groups_done, sets rr pointer to (g+1) mod M, and goes to IDLE.
  - If src_not_empty[g] drops mid-group: stall with grant held, no timeout.
  - Other sources' not_empty is ignored while LOCKED.
- abort while LOCKED:
  - Same cycle: src_rd_req[g]=1 and src_rd_all[g]=1. No slot_free or not_empty requirement.
  - No output is loaded, and the remaining lanes lane..N-1 are discarded.
  - Go to IDLE, rr pointer = g+1, groups_done unchanged.
- abort in IDLE: ignored.
- abort coinciding with a normal pop: abort wins, and the current lane is not emitted.
- rst mid-group: return to reset values. Source FIFOs must share the same rst, since partial groups are not reconciled.
- Invariants:
  - src_rd_req is at most one-hot.
  - src_rd_all is never set without src_rd_req.
  - out_lane increments by 1 within a group.
  - out_src is constant within a group.

Decomposition:
- Package nx1_arb_pkg holds:
  - state_t enum {IDLE, LOCKED}
  - localparam helpers for min-1 clog2 widths
  - a group-tag struct {src, lane, last}
- Sub-module rr_pick: M-bit request plus pointer in, one-hot grant plus index plus any out. Purely combinational, reused elsewhere.
- Top level holds the FSM, lane counter, output register and groups_done.

Test Plan:
- M=4, N=8; src 2 has one group, out_ready=1 -> 8 consecutive beats with out_src=2, out_lane=0..7, out_last only on lane 7, first out_valid 1 cycle after first pop, groups_done=1.
- Sources 0 and 1 both full from the start -> group order 0,1,0,1 and no interleaving within any group.
- out_ready toggles 1,0,0,1 mid-group -> no pops while out_valid & ~out_ready, data held, no lane skipped or duplicated.
- src_not_empty[g] deasserts for 5 cycles at lane 3 while src 3 is ready -> grant stays on g, resumes at lane 3, src 3 served only after lane 7.
- abort asserted at lane 4 -> single-cycle src_rd_req[g]=src_rd_all[g]=1, no out beat for lane 4, next group comes from g+1, groups_done unchanged.
- rst asserted at lane 5 -> next cycle out_valid=0, busy=0, rr pointer=0, groups_done=0; arbitration restarts from source 0.
